// File: rtl/pong_input_sequencer.sv
// Player input sequencer for the pong core: per-player paddle source select,
// frame-synchronous slew-limited paddle positions, and a coin pulse FSM with lockout.
module pong_input_sequencer #(
  parameter int COIN_CYCLES    = 35800,
  parameter int LOCKOUT_FRAMES = 30,
  parameter int SLEW_MAX       = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vsync,
  input  logic [1:0]  mode_p1,
  input  logic [1:0]  mode_p2,
  input  logic [15:0] analog_0,
  input  logic [15:0] analog_1,
  input  logic [7:0]  paddle_0,
  input  logic [7:0]  paddle_1,
  input  logic        start_req,
  input  logic        slew_en,
  output logic [7:0]  paddle1_vpos,
  output logic [7:0]  paddle2_vpos,
  output logic        coin_sw,
  output logic        busy
);

  localparam int CNT_W  = $clog2(COIN_CYCLES + 1);
  localparam int FCNT_W = $clog2(LOCKOUT_FRAMES + 1);
  localparam logic [8:0] SLEW_9 = 9'(SLEW_MAX);
  localparam logic [7:0] SLEW_8 = 8'(SLEW_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  logic vsync_q_reg;
  logic tick;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) vsync_q_reg <= 1'b0;
    else       vsync_q_reg <= vsync;
  end

  assign tick = vsync & ~vsync_q_reg;

  logic [1:0]  mode_arr  [2];
  logic [15:0] stick_arr [2];
  logic [7:0]  paddle_arr[2];
  logic [7:0]  vpos_arr  [2];

  assign mode_arr[0]   = mode_p1;
  assign mode_arr[1]   = mode_p2;
  assign stick_arr[0]  = analog_0;
  assign stick_arr[1]  = analog_1;
  assign paddle_arr[0] = paddle_0;
  assign paddle_arr[1] = paddle_1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [7:0] target;
      logic [8:0] diff;
      logic [7:0] step;
      logic [7:0] vpos_next;
      logic [7:0] vpos_reg;
      logic [1:0] mode_reg;
      logic       first_reg;

      always_comb begin
        case (mode_arr[gi])
          2'd0:    target = stick_arr[gi][15:8] + 8'h80;
          2'd1:    target = stick_arr[gi][7:0] + 8'h80;
          2'd2:    target = stick_arr[gi][7:0] ^ 8'h7F;
          default: target = paddle_arr[gi];
        endcase
      end

      // Distance is computed unsigned so the paddle walks the short way
      // along the screen, never wrapping 8'hFF <-> 8'h00.
      always_comb begin
        if (target >= vpos_reg) diff = {1'b0, target} - {1'b0, vpos_reg};
        else                    diff = {1'b0, vpos_reg} - {1'b0, target};
        step = (diff > SLEW_9) ? SLEW_8 : diff[7:0];
        if (target >= vpos_reg) vpos_next = vpos_reg + step;
        else                    vpos_next = vpos_reg - step;
        if (!slew_en || (mode_arr[gi] != mode_reg) || first_reg)
          vpos_next = target;
      end

      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          vpos_reg  <= 8'h80;
          mode_reg  <= 2'd0;
          first_reg <= 1'b1;
        end else if (tick) begin
          vpos_reg  <= vpos_next;
          mode_reg  <= mode_arr[gi];
          first_reg <= 1'b0;
        end
      end

      assign vpos_arr[gi] = vpos_reg;
    end
  endgenerate

  assign paddle1_vpos = vpos_arr[0];
  assign paddle2_vpos = vpos_arr[1];

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [FCNT_W-1:0] fcnt_reg;
  logic              coin_sw_reg;
  logic              start_prev_reg;
  logic              rise;

  assign rise = start_req & ~start_prev_reg;

  // start_prev resets high so a button held through reset never coins.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      fcnt_reg       <= '0;
      coin_sw_reg    <= 1'b0;
      start_prev_reg <= 1'b1;
    end else begin
      start_prev_reg <= start_req;
      case (state_reg)
        ST_IDLE: begin
          coin_sw_reg <= 1'b0;
          if (rise) begin
            state_reg   <= ST_PULSE;
            cnt_reg     <= '0;
            coin_sw_reg <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_reg == CNT_W'(COIN_CYCLES - 1)) begin
            state_reg   <= ST_LOCK;
            fcnt_reg    <= '0;
            coin_sw_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_LOCK: begin
          coin_sw_reg <= 1'b0;
          if (tick) begin
            if (fcnt_reg == FCNT_W'(LOCKOUT_FRAMES - 1)) state_reg <= ST_IDLE;
            else                                         fcnt_reg  <= fcnt_reg + FCNT_W'(1);
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          coin_sw_reg <= 1'b0;
        end
      endcase
    end
  end

  assign coin_sw = coin_sw_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule
